// File: rtl/bus_pkg.sv
// Shared system-bus definitions: tag field positions, device ids, line geometry
// and the memory responder state encoding.
package bus_pkg;

    localparam int unsigned TAG_RW_BIT = 12;
    localparam int unsigned TAG_DEV_HI = 11;
    localparam int unsigned TAG_DEV_LO = 8;

    localparam logic [3:0] DEV_MEM = 4'b0001;

    localparam int unsigned LINE_BEATS = 8;
    localparam int unsigned LINE_BYTES = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_WDATA
    } resp_state_t;

endpackage

// File: rtl/mem_array.sv
// Backing store: one synchronous write port, one combinational read port.
// Zero-latency read, no backpressure; contents survive reset.
module mem_array #(
    parameter int unsigned WORDS = 4096,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mem_responder.sv
// Bus memory responder: line reads as 8 held beats after LATENCY+1 cycles,
// line writes as 8 acked data beats; a beat waits for bus_respack, bus_reqcyc=0 stalls writes.
module mem_responder
    import bus_pkg::*;
#(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned MEM_WORDS      = 4096,
    parameter int unsigned LATENCY        = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    localparam int unsigned AW       = $clog2(MEM_WORDS);
    localparam int unsigned BW       = $clog2(LINE_BEATS);
    localparam int unsigned LW       = AW - BW;
    localparam int unsigned LINE_OFF = $clog2(LINE_BYTES);
    localparam int unsigned CW       = $clog2(LATENCY + 1);

    resp_state_t               state;
    logic [CW-1:0]             cnt;
    logic [BW-1:0]             beat;
    // Only the line bits that survive the modulo are kept; the rest wrap away.
    logic [LW-1:0]             line;

    logic                      hdr_hit;
    logic                      last_beat;
    logic                      wr_en;
    logic [BW-1:0]             rd_beat;
    logic [AW-1:0]             rd_idx;
    logic [AW-1:0]             wr_idx;
    logic [BUS_DATA_WIDTH-1:0] rd_data;

    always_comb begin
        hdr_hit   = bus_reqcyc && (bus_reqtag[TAG_DEV_HI:TAG_DEV_LO] == DEV_MEM);
        last_beat = (beat == BW'(LINE_BEATS - 1));
        // Look one beat ahead so the registered bus_resp is ready at the ack edge.
        rd_beat   = (state == ST_RESP) ? beat + BW'(1) : '0;
        rd_idx    = {line, rd_beat};
        wr_idx    = {line, beat};
        wr_en     = !reset && (state == ST_WDATA) && bus_reqcyc;
    end

    mem_array #(
        .WORDS (MEM_WORDS),
        .WIDTH (BUS_DATA_WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_idx),
        .wr_data (bus_req),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            beat        <= '0;
            line        <= '0;
            bus_reqack  <= 1'b0;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            bus_resptag <= '0;
        end else begin
            bus_reqack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hdr_hit) begin
                        line        <= bus_req[LINE_OFF +: LW];
                        bus_resptag <= bus_reqtag;
                        bus_reqack  <= 1'b1;
                        beat        <= '0;
                        if (bus_reqtag[TAG_RW_BIT]) begin
                            state <= ST_WAIT;
                            cnt   <= CW'(LATENCY);
                        end else begin
                            state <= ST_WDATA;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state       <= ST_RESP;
                        beat        <= '0;
                        bus_respcyc <= 1'b1;
                        bus_resp    <= rd_data;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_RESP: begin
                    if (bus_respack) begin
                        if (last_beat) begin
                            state       <= ST_IDLE;
                            beat        <= '0;
                            bus_respcyc <= 1'b0;
                            bus_resp    <= '0;
                        end else begin
                            beat     <= beat + BW'(1);
                            bus_resp <= rd_data;
                        end
                    end
                end
                ST_WDATA: begin
                    if (bus_reqcyc) begin
                        bus_reqack <= 1'b1;
                        if (last_beat) begin
                            state <= ST_IDLE;
                            beat  <= '0;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a word-array model predicts each read burst,
// and a negedge monitor checks every response cycle against the expected queue.
module tb_mem_responder;

    localparam int unsigned DW    = 64;
    localparam int unsigned TW    = 13;
    localparam int unsigned WORDS = 4096;
    localparam int unsigned LAT   = 4;

    typedef struct {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack;

    mem_responder #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .MEM_WORDS      (WORDS),
        .LATENCY        (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            ack_cnt = 0;
    int            resp_cycles = 0;
    int            beats_done = 0;
    int            first_cyc = 0;
    logic [DW-1:0] first_data = '0;
    bit            first_pending = 0;
    bit            mon_en = 0;
    exp_t          q[$];
    logic [DW-1:0] mm [WORDS];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int widx(input logic [DW-1:0] addr, input int i);
        return int'(((addr >> 6) * 8 + DW'(i)) % DW'(WORDS));
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_reqack) ack_cnt++;
            if (bus_respcyc) begin
                resp_cycles++;
                if (first_pending) begin
                    first_pending = 0;
                    first_cyc     = cyc;
                    first_data    = bus_resp;
                end
                if (q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    chk("resp_data", bus_resp, q[0].d);
                    chk("resp_tag", DW'(bus_resptag), DW'(q[0].t));
                    if (bus_respack) begin
                        void'(q.pop_front());
                        beats_done++;
                    end
                end
            end else begin
                chk("resp_idle_zero", bus_resp, '0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [DW-1:0] addr, input logic [TW-1:0] tag);
        for (int i = 0; i < 8; i++) q.push_back('{d: mm[widx(addr, i)], t: tag});
    endtask

    task automatic do_write(input logic [DW-1:0] addr, input logic [DW-1:0] base, input bit gap);
        int a0;
        a0 = ack_cnt;
        bus_reqcyc = 1; bus_req = addr; bus_reqtag = 13'h0100;
        tick();
        chk("wr_hdr_ack", DW'(bus_reqack), 1);
        for (int i = 0; i < 8; i++) begin
            if (gap) begin
                bus_reqcyc = 0;
                tick();
            end
            bus_reqcyc = 1; bus_req = base * DW'(i + 1);
            mm[widx(addr, i)] = bus_req;
            tick();
        end
        bus_reqcyc = 0;
        repeat (3) tick();
        chk("wr_ack_count", DW'(ack_cnt - a0), 9);
    endtask

    task automatic wait_drain(input int mode);
        bit waited = 0;
        for (int n = 0; n < 200 && q.size() > 0; n++) begin
            if (mode == 0) begin
                bus_respack = 1;
            end else begin
                bus_respack = bus_respcyc ? waited : 1'b0;
                waited      = bus_respcyc ? !waited : 1'b0;
            end
            tick();
        end
        if (q.size() != 0) begin
            chk("drain_timeout", DW'(q.size()), 0);
            q.delete();
        end
        bus_respack = 0;
    endtask

    task automatic do_read(input logic [DW-1:0] addr, input int mode, input int exp_cycles, input bit chk_lat);
        int t0;
        int r0;
        r0 = resp_cycles;
        push_line(addr, 13'h1100);
        first_pending = 1;
        bus_reqcyc = 1; bus_req = addr; bus_reqtag = 13'h1100;
        tick();
        t0 = cyc;
        bus_reqcyc = 0;
        chk("rd_hdr_ack", DW'(bus_reqack), 1);
        wait_drain(mode);
        tick();
        chk("rd_resp_cycles", DW'(resp_cycles - r0), DW'(exp_cycles));
        if (chk_lat) chk("rd_first_latency", DW'(first_cyc - t0), DW'(LAT + 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int a0, r0, b0;
        reset = 1; bus_reqcyc = 0; bus_req = '0; bus_reqtag = '0; bus_respack = 0;
        repeat (3) tick();
        chk("rst_reqack", DW'(bus_reqack), 0);
        chk("rst_respcyc", DW'(bus_respcyc), 0);
        chk("rst_resp", bus_resp, 0);
        chk("rst_resptag", DW'(bus_resptag), 0);
        reset = 0;
        mon_en = 1;
        tick();

        // Gapped write to line 0x40 and ungapped write to line 0x80.
        r0 = resp_cycles;
        do_write(64'h40, 64'h11, 1);
        chk("wr_no_resp", DW'(resp_cycles - r0), 0);
        do_write(64'h80, 64'hA0A0_0000_0000_0101, 0);

        do_read(64'h40, 0, 8, 1);
        chk("rd_first_beat", first_data, 64'h11);
        do_read(64'h40, 1, 16, 0);
        do_read(64'h47, 0, 8, 0);
        chk("rd_47_first", first_data, 64'h11);
        do_read(DW'(WORDS * 8 + 'h40), 0, 8, 0);
        chk("rd_wrap_first", first_data, 64'h11);
        do_read(64'h80, 1, 16, 0);
        chk("rd_80_first", first_data, 64'hA0A0_0000_0000_0101);

        // Foreign device id must be ignored entirely.
        a0 = ack_cnt; r0 = resp_cycles;
        bus_reqcyc = 1; bus_req = 64'h40; bus_reqtag = 13'h1200;
        repeat (4) tick();
        bus_reqcyc = 0;
        repeat (8) tick();
        chk("dev2_no_ack", DW'(ack_cnt - a0), 0);
        chk("dev2_no_resp", DW'(resp_cycles - r0), 0);

        // A second header held during RESP is acked only after the burst ends.
        b0 = beats_done;
        push_line(64'h40, 13'h1100);
        push_line(64'h80, 13'h1100);
        bus_reqcyc = 1; bus_req = 64'h40; bus_reqtag = 13'h1100;
        tick();
        bus_reqcyc = 0;
        bus_respack = 1;
        for (int n = 0; n < 50 && !bus_respcyc; n++) tick();
        bus_reqcyc = 1; bus_req = 64'h80;
        begin : wait_ack
            for (int n = 0; n < 50; n++) begin
                @(negedge clk);
                if (bus_reqack) disable wait_ack;
            end
            chk("held_req_ack_timeout", 0, 1);
        end
        chk("held_req_after_burst", DW'(beats_done - b0), 8);
        tick();
        bus_reqcyc = 0;
        wait_drain(0);
        tick();

        // Reset while beat 3 is on the bus.
        b0 = beats_done;
        push_line(64'h40, 13'h1100);
        bus_reqcyc = 1; bus_req = 64'h40; bus_reqtag = 13'h1100;
        tick();
        bus_reqcyc = 0;
        bus_respack = 1;
        repeat (LAT + 4) tick();
        chk("pre_rst_beat3", bus_resp, 64'h44);
        reset = 1;
        tick();
        reset = 0;
        bus_respack = 0;
        q.delete();
        chk("mid_rst_respcyc", DW'(bus_respcyc), 0);
        chk("mid_rst_resp", bus_resp, 0);
        chk("mid_rst_beats", DW'(beats_done - b0), 4);
        tick();
        do_read(64'h40, 0, 8, 1);
        chk("post_rst_first", first_data, 64'h11);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
